conv_mac_engine: RTL and testbench

Multiply-accumulate datapath that sits directly downstream of the convolution address controller. It consumes one pixel/coefficient pair per valid cycle, read from image and kernel memory at the controller's image and kernel addresses. It accumulates KER_SIZE×KER_SIZE taps per output pixel, then scales and clamps the sum. It emits one 8-bit filtered pixel with its filtered-image write address, driving the output memory's write port.

---
 rtl/conv_mac_engine_if.sv | 23 ++
 rtl/conv_mac_engine.sv | 100 ++++++++++
 tb/tb_conv_mac_engine.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_engine_if.sv
// Tap input and filtered-pixel output bundle for conv_mac_engine.
// The master drives taps and clear; the slave is the MAC engine.
interface conv_mac_engine_if;
    logic        clear;
    logic        in_valid;
    logic [7:0]  pixel;
    logic [7:0]  coeff;
    logic [15:0] filt_addr;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        busy;

    modport master (
        output clear, in_valid, pixel, coeff, filt_addr,
        input  out_valid, out_data, out_addr, busy
    );

    modport slave (
        input  clear, in_valid, pixel, coeff, filt_addr,
        output out_valid, out_data, out_addr, busy
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Two-stage pixel x coefficient MAC: one scaled, clamped 8-bit pixel per KER_SIZE^2-tap window.
// Define CONV_ABS_EN to scale the magnitude of the window sum instead of clamping negative sums to 0.
module conv_mac_engine #(
    parameter int KER_SIZE = 3,
    parameter int SHIFT    = 0,
    parameter int ACC_W    = 21
) (
    input  logic             clk,
    input  logic             rst,
    conv_mac_engine_if.slave bus
);
    localparam int TAPS  = KER_SIZE * KER_SIZE;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    logic [TAP_W-1:0]        tap;
    logic                    last;
    logic signed [16:0]      prod;
    logic signed [16:0]      prod_next;
    logic                    p_valid;
    logic                    p_last;
    logic [15:0]             p_addr;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] shifted;
    logic [7:0]              scaled;
    logic                    out_valid;
    logic [7:0]              out_data;
    logic [15:0]             out_addr;

    assign last      = bus.in_valid && (tap == LAST_TAP);
    assign prod_next = $signed({9'd0, bus.pixel}) * $signed({{9{bus.coeff[7]}}, bus.coeff});
    assign sum       = acc + {{(ACC_W-17){prod[16]}}, prod};

    // The final tap's product is folded in here rather than in acc, so windows need no bubble.
    always_comb begin
        mag     = sum;
        shifted = '0;
        scaled  = 8'd0;
`ifdef CONV_ABS_EN
        if (sum[ACC_W-1]) begin
            mag = -sum;
        end
`endif
        shifted = mag >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            scaled = 8'd0;
        end else if (shifted > ACC_W'(255)) begin
            scaled = 8'hFF;
        end else begin
            scaled = shifted[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap       <= '0;
            prod      <= '0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_addr    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (bus.clear) begin
            tap       <= '0;
            acc       <= '0;
            p_valid   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                tap  <= last ? '0 : tap + TAP_W'(1);
                prod <= prod_next;
            end
            if (last) begin
                p_addr <= bus.filt_addr;
            end
            p_valid   <= bus.in_valid;
            p_last    <= last;
            out_valid <= 1'b0;
            if (p_valid) begin
                if (p_last) begin
                    acc       <= '0;
                    out_data  <= scaled;
                    out_addr  <= p_addr;
                    out_valid <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_addr  = out_addr;
    assign bus.busy      = (tap != '0) || p_valid;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: three instances (SHIFT 0, 2, 3) share one tap stream
// and are compared every cycle against a window-sum reference model, plus literal expectations.
`timescale 1ns/1ps
module tb_conv_mac_engine;
    localparam int TAPS = 9;
    localparam int N    = 3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  pixel     = 8'd0;
    logic [7:0]  coeff     = 8'd0;
    logic [15:0] filt_addr = 16'd0;

    conv_mac_engine_if bus0 ();
    conv_mac_engine_if bus1 ();
    conv_mac_engine_if bus2 ();

    assign bus0.clear = clear;  assign bus0.in_valid = in_valid;  assign bus0.pixel = pixel;
    assign bus0.coeff = coeff;  assign bus0.filt_addr = filt_addr;
    assign bus1.clear = clear;  assign bus1.in_valid = in_valid;  assign bus1.pixel = pixel;
    assign bus1.coeff = coeff;  assign bus1.filt_addr = filt_addr;
    assign bus2.clear = clear;  assign bus2.in_valid = in_valid;  assign bus2.pixel = pixel;
    assign bus2.coeff = coeff;  assign bus2.filt_addr = filt_addr;

    conv_mac_engine #(.KER_SIZE(3), .SHIFT(0), .ACC_W(21)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv_mac_engine #(.KER_SIZE(3), .SHIFT(2), .ACC_W(21)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    conv_mac_engine #(.KER_SIZE(3), .SHIFT(3), .ACC_W(21)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic        ov [N];
    logic [7:0]  od [N];
    logic [15:0] oa [N];
    logic        ob [N];
    assign ov[0] = bus0.out_valid;  assign od[0] = bus0.out_data;  assign oa[0] = bus0.out_addr;  assign ob[0] = bus0.busy;
    assign ov[1] = bus1.out_valid;  assign od[1] = bus1.out_data;  assign oa[1] = bus1.out_addr;  assign ob[1] = bus1.busy;
    assign ov[2] = bus2.out_valid;  assign od[2] = bus2.out_data;  assign oa[2] = bus2.out_addr;  assign ob[2] = bus2.busy;

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [15:0]      addr;
        logic [N-1:0][7:0] data;
    } exp_t;

    typedef struct packed {
        int          c;
        logic [7:0]  d;
        logic [15:0] a;
    } log_t;

    exp_t        exp_q [$];
    exp_t        new_exp;
    log_t        log0 [$];
    int          cyc      = 0;
    int          win_sum  = 0;
    int          win_cnt  = 0;
    bit          acc_prev = 1'b0;
    logic [7:0]  last_data [N];
    logic [15:0] last_addr [N];
    int          strobes   [N];
    logic [7:0]  got_data  [N];
    logic [15:0] got_addr  [N];
    int          got_cyc   [N];
    int          total = 0;
    int          bad   = 0;

    function automatic int shift_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int scale_model(input int s, input int sh);
        int v;
`ifdef CONV_ABS_EN
        v = (s < 0 ? -s : s) >>> sh;
`else
        v = s >>> sh;
`endif
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic check_output(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, idx, cyc, got, want);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        win_sum  = 0;
        win_cnt  = 0;
        acc_prev = 1'b0;
    endtask

    // Reference model: sum each completed window arithmetically and schedule its result two cycles on.
    always @(posedge clk) begin
        if (!rst) begin
            flush_model();
        end else if (clear) begin
            win_sum  = 0;
            win_cnt  = 0;
            acc_prev = 1'b0;
            while (exp_q.size() > 0 && exp_q[$].due > cyc) exp_q.pop_back();
        end else if (in_valid) begin
            win_sum  += int'(pixel) * int'($signed(coeff));
            win_cnt  += 1;
            acc_prev = 1'b1;
            if (win_cnt == TAPS) begin
                new_exp.due  = cyc + 2;
                new_exp.addr = filt_addr;
                for (int i = 0; i < N; i++) new_exp.data[i] = 8'(scale_model(win_sum, shift_of(i)));
                exp_q.push_back(new_exp);
                win_sum = 0;
                win_cnt = 0;
            end
        end else begin
            acc_prev = 1'b0;
        end
        cyc++;
    end

    // Compare process: every output of every instance, every cycle.
    always @(negedge clk) begin
        bit due_now;
        if (!rst) begin
            flush_model();
            for (int i = 0; i < N; i++) begin
                last_data[i] = 8'd0;
                last_addr[i] = 16'd0;
                check_output("rst_out_valid", i, 32'(ov[i]), 32'd0);
                check_output("rst_out_data", i, 32'(od[i]), 32'd0);
                check_output("rst_out_addr", i, 32'(oa[i]), 32'd0);
                check_output("rst_busy", i, 32'(ob[i]), 32'd0);
            end
        end else begin
            due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            for (int i = 0; i < N; i++) begin
                check_output("out_valid", i, 32'(ov[i]), 32'(due_now));
                if (due_now) begin
                    check_output("out_data", i, 32'(od[i]), 32'(exp_q[0].data[i]));
                    check_output("out_addr", i, 32'(oa[i]), 32'(exp_q[0].addr));
                    last_data[i] = exp_q[0].data[i];
                    last_addr[i] = exp_q[0].addr;
                end else begin
                    check_output("hold_data", i, 32'(od[i]), 32'(last_data[i]));
                    check_output("hold_addr", i, 32'(oa[i]), 32'(last_addr[i]));
                end
                check_output("busy", i, 32'(ob[i]), 32'((win_cnt != 0) || acc_prev));
                if (ov[i] === 1'b1) begin
                    strobes[i]++;
                    got_data[i] = od[i];
                    got_addr[i] = oa[i];
                    got_cyc[i]  = cyc;
                    if (i == 0) log0.push_back('{c: cyc, d: od[i], a: oa[i]});
                end
            end
            if (due_now) void'(exp_q.pop_front());
        end
    end

    task automatic apply_stimulus(input logic v, input logic clr, input logic [7:0] pix,
                                  input logic [7:0] cf, input logic [15:0] addr);
        in_valid  = v;
        clear     = clr;
        pixel     = pix;
        coeff     = cf;
        filt_addr = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
    endtask

    task automatic send_identity(input logic [7:0] centre, input logic [15:0] addr);
        for (int t = 0; t < TAPS; t++)
            apply_stimulus(1'b1, 1'b0, (t == 4) ? centre : 8'($urandom), (t == 4) ? 8'd1 : 8'd0,
                           (t == TAPS - 1) ? addr : 16'($urandom));
    endtask

    task automatic send_flat(input logic [7:0] pix, input logic [7:0] cf, input logic [15:0] addr);
        for (int t = 0; t < TAPS; t++) apply_stimulus(1'b1, 1'b0, pix, cf, addr);
    endtask

    initial begin
        int s0;
        int t_last;
        int t0;
        bit v;
        bit clr;
        logic [7:0] cf;
        for (int i = 0; i < N; i++) begin
            last_data[i] = 8'd0;
            last_addr[i] = 16'd0;
            strobes[i]   = 0;
            got_data[i]  = 8'd0;
            got_addr[i]  = 16'd0;
            got_cyc[i]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Identity kernel, pixels 1..9: centre pixel 5 appears two cycles after the last tap.
        s0 = strobes[0];
        for (int t = 0; t < TAPS; t++) begin
            if (t == TAPS - 1) t_last = cyc;
            apply_stimulus(1'b1, 1'b0, 8'(t + 1), (t == 4) ? 8'd1 : 8'd0, (t == TAPS - 1) ? 16'h0042 : 16'($urandom));
        end
        idle(3);
        check_output("ident_count", 0, 32'(strobes[0] - s0), 32'd1);
        check_output("ident_data", 0, 32'(got_data[0]), 32'd5);
        check_output("ident_addr", 0, 32'(got_addr[0]), 32'h0042);
        check_output("ident_latency", 0, 32'(got_cyc[0] - t_last), 32'd2);

        send_flat(8'd200, 8'd1, 16'h0100);
        idle(3);
        check_output("box_shift3", 2, 32'(got_data[2]), 32'd225);

        send_flat(8'd255, 8'd1, 16'h0101);
        idle(3);
        check_output("box_clamp", 0, 32'(got_data[0]), 32'd255);

        send_flat(8'd100, 8'hFF, 16'h0102);
        idle(3);
`ifdef CONV_ABS_EN
        check_output("neg_kernel", 1, 32'(got_data[1]), 32'd225);
`else
        check_output("neg_kernel", 1, 32'(got_data[1]), 32'd0);
`endif

        // Back-to-back windows, no bubble between them.
        s0 = strobes[0];
        t0 = cyc;
        send_identity(8'd7, 16'h0010);
        send_identity(8'd9, 16'h0011);
        idle(4);
        check_output("b2b_count", 0, 32'(strobes[0] - s0), 32'd2);
        if (log0.size() >= 2) begin
            check_output("b2b_first_cyc", 0, 32'(log0[$-1].c - t0), 32'd10);
            check_output("b2b_first_data", 0, 32'(log0[$-1].d), 32'd7);
            check_output("b2b_first_addr", 0, 32'(log0[$-1].a), 32'h0010);
            check_output("b2b_second_cyc", 0, 32'(log0[$].c - t0), 32'd19);
            check_output("b2b_second_data", 0, 32'(log0[$].d), 32'd9);
            check_output("b2b_second_addr", 0, 32'(log0[$].a), 32'h0011);
        end else begin
            check_output("b2b_log_size", 0, 32'(log0.size()), 32'd2);
        end

        // Clear mid-window, with a simultaneous tap that must be dropped.
        s0 = strobes[0];
        for (int t = 0; t < 4; t++) apply_stimulus(1'b1, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
        apply_stimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 16'($urandom));
        check_output("clear_busy", 0, 32'(ob[0]), 32'd0);
        send_identity(8'd33, 16'h0200);
        idle(3);
        check_output("clear_count", 0, 32'(strobes[0] - s0), 32'd1);
        check_output("clear_data", 0, 32'(got_data[0]), 32'd33);
        check_output("clear_addr", 0, 32'(got_addr[0]), 32'h0200);

        // Asynchronous reset mid-window.
        s0 = strobes[0];
        for (int t = 0; t < 5; t++) apply_stimulus(1'b1, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_output("async_rst_data", 0, 32'(od[0]), 32'd0);
        check_output("async_rst_addr", 0, 32'(oa[0]), 32'd0);
        check_output("async_rst_busy", 0, 32'(ob[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_identity(8'd44, 16'h0300);
        idle(3);
        check_output("post_rst_count", 0, 32'(strobes[0] - s0), 32'd1);
        check_output("post_rst_data", 0, 32'(got_data[0]), 32'd44);

        // Random taps, gaps and occasional clears; small coefficients half the time to avoid constant clamping.
        for (int k = 0; k < 600; k++) begin
            v   = ($urandom_range(0, 99) < 75);
            clr = ($urandom_range(0, 99) < 3);
            cf  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) - 8'd3 : 8'($urandom);
            apply_stimulus(v, clr, 8'($urandom), cf, 16'($urandom));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
